// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Sequences a 16-bit, N-word synchronous-read instruction memory.
//             Boot-loads a program through a valid/ready stream, then issues a
//             fetch address every cycle and delivers PC/instruction pairs to
//             the IF/ID register. Handles stall, branch redirect with squash,
//             PC wrap-around and a sticky halt opcode.
//  Ports    : clk, rst (async, active-low)
//             load_valid/load_data/load_last -> load_ready   boot-load stream
//             imem_addr/imem_we/imem_wdata, imem_rdata        memory interface
//             stall, branch_taken, branch_target              pipeline control
//             if_pc/if_instr/if_valid                         IF/ID payload
//             halted, fetch_err                               sticky status
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int         N       = 16,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic [15:0] imem_addr,
    output logic        imem_we,
    output logic [15:0] imem_wdata,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] if_pc,
    output logic [15:0] if_instr,
    output logic        if_valid,
    output logic        halted,
    output logic        fetch_err
);

    localparam logic [15:0] c_LAST  = 16'(N - 1);
    localparam logic [16:0] c_DEPTH = 17'(N);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_lptr;
    logic [15:0] r_pc;
    logic [15:0] r_issued;      // address whose read data arrives next cycle
    logic [15:0] r_addr_q;      // last driven address, replayed while halted
    logic [15:0] r_if_pc;
    logic [15:0] r_if_instr;
    logic        r_if_valid;
    logic        r_halted;
    logic        r_fetch_err;

    logic        w_accept;
    logic        w_load_ready;
    logic        w_we;
    logic [15:0] w_addr;
    logic [15:0] w_wdata;
    logic        w_tgt_ok;
    logic [15:0] w_tgt;

    function automatic logic [15:0] f_next(input logic [15:0] p);
        return (p == c_LAST) ? 16'd0 : p + 16'd1;
    endfunction

    // Out-of-range redirect targets fall back to address 0.
    assign w_tgt_ok = ({1'b0, branch_target} < c_DEPTH);
    assign w_tgt    = w_tgt_ok ? branch_target : 16'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_load_ready = 1'b0;
        w_we         = 1'b0;
        w_addr       = r_addr_q;
        w_wdata      = 16'd0;
        case (r_state)
            S_LOAD: begin
                // Gated by rst so the stream handshake is dead while in reset.
                w_load_ready = rst;
                w_addr       = r_lptr;
                if (load_valid && rst) begin
                    w_accept = 1'b1;
                    w_we     = 1'b1;
                    w_wdata  = load_data;
                    if (load_last || (r_lptr == c_LAST)) begin
                        w_next = S_PRIME;
                    end
                end
            end
            S_PRIME: begin
                w_addr = 16'd0;
                w_next = S_RUN;
            end
            S_RUN: begin
                if (branch_taken) begin
                    w_addr = w_tgt;
                end else if (stall) begin
                    // Re-issue the pending address so its data is still there.
                    w_addr = r_issued;
                end else begin
                    w_addr = r_pc;
                    if (imem_rdata[15:12] == HALT_OP) begin
                        w_next = S_HALT;
                    end
                end
            end
            default: begin
                w_next = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lptr      <= 16'd0;
            r_pc        <= 16'd0;
            r_issued    <= 16'd0;
            r_addr_q    <= 16'd0;
            r_if_pc     <= 16'd0;
            r_if_instr  <= 16'd0;
            r_if_valid  <= 1'b0;
            r_halted    <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            r_addr_q <= w_addr;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_lptr <= r_lptr + 16'd1;
                    end
                end
                S_PRIME: begin
                    r_pc     <= f_next(16'd0);
                    r_issued <= 16'd0;
                end
                S_RUN: begin
                    if (branch_taken) begin
                        // Squash the in-flight read; one bubble follows.
                        r_if_valid <= 1'b0;
                        r_issued   <= w_tgt;
                        r_pc       <= f_next(w_tgt);
                        if (!w_tgt_ok) begin
                            r_fetch_err <= 1'b1;
                        end
                    end else if (!stall) begin
                        r_if_instr <= imem_rdata;
                        r_if_pc    <= r_issued;
                        r_if_valid <= 1'b1;
                        r_issued   <= r_pc;
                        r_pc       <= f_next(r_pc);
                        if (imem_rdata[15:12] == HALT_OP) begin
                            r_halted <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_if_valid <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = w_load_ready;
    assign imem_we    = w_we;
    assign imem_addr  = w_addr;
    assign imem_wdata = w_wdata;
    assign if_pc      = r_if_pc;
    assign if_instr   = r_if_instr;
    assign if_valid   = r_if_valid;
    assign halted     = r_halted;
    assign fetch_err  = r_fetch_err;

endmodule
`default_nettype wire
